// File: rtl/fp_add_sequencer.sv
// Host-side sequencer for the multi-cycle FP32 adder: accepts operand pairs, runs the
// adder through start/done/clear, bypasses zero operands and recovers a hung adder.
//
// state | meaning
// IDLE  | ready for an operand pair
// ISSUE | add_start high for one cycle
// WAIT  | waiting for add_done or timeout
// CLEAR | add_clr high for one cycle
// HOLD  | result presented until out_ready
module fp_add_sequencer #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    output logic             add_start,
    output logic             add_clr,
    output logic [31:0]      add_a,
    output logic [31:0]      add_b,
    input  logic             add_done,
    input  logic [31:0]      add_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_sum,
    output logic             out_err,
    output logic [CNT_W-1:0] op_count
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        CLEAR,
        HOLD
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic          armed;
    logic          a_zero;
    logic          b_zero;

    assign a_zero = (in_a[30:0] == 31'd0);
    assign b_zero = (in_b[30:0] == 31'd0);

    // armed keeps in_ready low for the first cycle after reset release
    assign in_ready  = (state == IDLE) && armed;
    assign add_start = (state == ISSUE);
    assign add_clr   = (state == CLEAR) || clr;
    assign out_valid = (state == HOLD);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state    <= IDLE;
            timer    <= '0;
            armed    <= 1'b0;
            add_a    <= '0;
            add_b    <= '0;
            out_sum  <= '0;
            out_err  <= 1'b0;
            op_count <= '0;
        end else begin
            armed <= 1'b1;
            case (state)
                IDLE: begin
                    if (in_valid && armed) begin
                        add_a <= in_a;
                        add_b <= in_b;
                        if (a_zero || b_zero) begin
                            // a zero A yields B, so +0 + -0 gives -0
                            out_sum <= a_zero ? in_b : in_a;
                            out_err <= 1'b0;
                            state   <= HOLD;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    timer <= timer + TW'(1);
                    if (add_done) begin
                        out_sum <= add_sum;
                        out_err <= 1'b0;
                        state   <= CLEAR;
                    end else if (timer == TIMER_LAST) begin
                        out_sum <= '0;
                        out_err <= 1'b1;
                        state   <= CLEAR;
                    end
                end
                CLEAR: begin
                    state <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        op_count <= op_count + CNT_W'(1);
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_add_sequencer.sv
// Directed bench for fp_add_sequencer with a behavioural stub adder and a result scoreboard.
module tb_fp_add_sequencer;

    logic        clk = 1'b0;
    logic        clr;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        add_start;
    logic        add_clr;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_done;
    logic [31:0] add_sum;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic        out_err;
    logic [3:0]  op_count;

    typedef struct packed {
        logic [31:0] sum;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          passed = 0;
    int          start_cnt = 0;
    int          clr_cnt = 0;
    int          model_delay = 4;
    logic [31:0] model_sum = 32'd0;
    int          mcnt = 0;
    bit          mbusy = 1'b0;
    logic [3:0]  exp_cnt = 4'd0;

    always #5 clk = ~clk;

    fp_add_sequencer #(.TIMEOUT(16), .CNT_W(4)) dut (
        .clk       (clk),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .add_start (add_start),
        .add_clr   (add_clr),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_done  (add_done),
        .add_sum   (add_sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_err   (out_err),
        .op_count  (op_count)
    );

    // stub adder: samples add_start on the falling edge, raises done model_delay cycles later
    initial begin
        add_done = 1'b0;
        add_sum  = 32'd0;
    end
    always @(negedge clk) begin
        if (add_clr) begin
            add_done = 1'b0;
            mbusy    = 1'b0;
            mcnt     = 0;
        end else if (add_start) begin
            mbusy = 1'b1;
            mcnt  = model_delay;
        end else if (mbusy) begin
            mcnt = mcnt - 1;
            if (mcnt == 0) begin
                add_done = 1'b1;
                add_sum  = model_sum;
                mbusy    = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (!clr) begin
            if (add_start) start_cnt = start_cnt + 1;
            if (add_clr)   clr_cnt   = clr_cnt + 1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        check("accept_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] esum, input logic eerr);
        exp_t e;
        e.sum = esum;
        e.err = eerr;
        sb.push_back(e);
        accept(a, b);
    endtask

    task automatic collect(input int stall);
        int   n = 0;
        exp_t e;
        while (!out_valid && n < 200) begin
            tick();
            n++;
        end
        check("out_valid_seen", {31'd0, out_valid}, 32'd1);
        if (out_valid) begin
            if (sb.size() == 0) begin
                check("sb_nonempty", 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                check("out_sum", out_sum, e.sum);
                check("out_err", {31'd0, out_err}, {31'd0, e.err});
                for (int i = 0; i < stall; i++) begin
                    tick();
                    check("stall_valid", {31'd0, out_valid}, 32'd1);
                    check("stall_sum", out_sum, e.sum);
                    check("stall_in_ready", {31'd0, in_ready}, 32'd0);
                end
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            exp_cnt = exp_cnt + 4'd1;
            check("op_count", {28'd0, op_count}, {28'd0, exp_cnt});
            check("valid_drop", {31'd0, out_valid}, 32'd0);
        end
    endtask

    initial begin
        clr       = 1'b1;
        in_valid  = 1'b0;
        in_a      = 32'd0;
        in_b      = 32'd0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_add_clr", {31'd0, add_clr}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_add_start", {31'd0, add_start}, 32'd0);
        check("rst_op_count", {28'd0, op_count}, 32'd0);
        check("rst_out_sum", out_sum, 32'd0);
        check("rst_add_a", add_a, 32'd0);
        clr = 1'b0;
        tick();
        check("rel_in_ready", {31'd0, in_ready}, 32'd1);

        // normal add through the stub
        start_cnt = 0;
        clr_cnt = 0;
        model_delay = 4;
        model_sum = 32'h4040_0000;
        send(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 1'b0);
        check("issue_start", {31'd0, add_start}, 32'd1);
        check("issue_add_a", add_a, 32'h3F80_0000);
        check("issue_add_b", add_b, 32'h4000_0000);
        tick();
        check("start_drop", {31'd0, add_start}, 32'd0);
        collect(0);
        check("normal_starts", start_cnt, 32'd1);
        check("normal_clrs", clr_cnt, 32'd1);

        // reset in the middle of WAIT
        model_delay = 1000;
        accept(32'h3F80_0000, 32'h3F80_0000);
        repeat (4) tick();
        clr = 1'b1;
        #1;
        check("mid_add_clr", {31'd0, add_clr}, 32'd1);
        check("mid_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_op_count", {28'd0, op_count}, 32'd0);
        check("mid_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        clr = 1'b0;
        exp_cnt = 4'd0;
        tick();
        check("mid_rel_ready", {31'd0, in_ready}, 32'd1);
        check("mid_rel_valid", {31'd0, out_valid}, 32'd0);

        // zero bypass
        start_cnt = 0;
        send(32'h0000_0000, 32'hC120_0000, 32'hC120_0000, 1'b0);
        check("bypass_latency", {31'd0, out_valid}, 32'd1);
        collect(0);
        send(32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0);
        collect(0);
        send(32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 1'b0);
        collect(0);
        check("bypass_no_start", start_cnt, 32'd0);

        // timeout, then done arriving on the final WAIT cycle, then one cycle too late
        clr_cnt = 0;
        model_delay = 1000;
        send(32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 1'b1);
        collect(0);
        check("timeout_clr", clr_cnt, 32'd1);
        model_delay = 16;
        model_sum = 32'h4100_0000;
        send(32'h4080_0000, 32'h4080_0000, 32'h4100_0000, 1'b0);
        collect(0);
        model_delay = 17;
        send(32'h4080_0000, 32'h4080_0000, 32'h0000_0000, 1'b1);
        collect(0);

        // backpressure with a second pair waiting
        model_delay = 3;
        model_sum = 32'h4110_0000;
        send(32'h4000_0000, 32'h40E0_0000, 32'h4110_0000, 1'b0);
        in_valid = 1'b1;
        in_a = 32'h0000_0000;
        in_b = 32'h3F80_0000;
        collect(10);
        send(32'h0000_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b0);
        collect(0);

        // fill to 15 results, then wrap
        while (exp_cnt != 4'd15) begin
            logic [31:0] r;
            r = $urandom();
            send(32'h0000_0000, r, r, 1'b0);
            collect(0);
        end
        check("pre_wrap", {28'd0, op_count}, 32'd15);
        send(32'h0000_0000, 32'h3F00_0000, 32'h3F00_0000, 1'b0);
        collect(0);
        check("wrap_zero", {28'd0, op_count}, 32'd0);
        check("sb_drained", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
